// File: rtl/memory_dp_clr.sv
// Dual-port word store: port A read/write with byte lanes, port B read-only.
// A clear engine zeroes the array one word per clock after reset.
module memory_dp_clr #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    busy,
  input  logic                    a_en,
  input  logic                    a_write_en,
  input  logic [DATA_WIDTH/8-1:0] a_byte_en,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH-1:0]   a_data_in,
  output logic [DATA_WIDTH-1:0]   a_read_data,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  output logic [DATA_WIDTH-1:0]   b_read_data,
  output logic                    b_valid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  clr_we;

  logic                  a_in;
  logic                  b_in;
  logic                  a_acc;
  logic                  b_acc;
  logic                  a_wr;
  logic [DATA_WIDTH-1:0] a_old;
  logic [DATA_WIDTH-1:0] a_merged;
  logic [DATA_WIDTH-1:0] a_s1;
  logic [DATA_WIDTH-1:0] b_s1;

  logic [DATA_WIDTH-1:0] a_d1;
  logic [DATA_WIDTH-1:0] b_d1;
  logic                  a_v1;
  logic                  b_v1;

  assign clr_last = (clr_cnt == LAST);

  // State register: reset always restarts from CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  // Next state: leave CLEAR after the last word, or at once if skipping
  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: begin
        if (CLEAR_ON_RESET == 0 || clr_last)
          state_nx = READY;
      end
      READY: state_nx = READY;
      default: state_nx = CLEAR;
    endcase
  end

  // FSM outputs: busy gates both ports while clearing
  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR) && (CLEAR_ON_RESET != 0);
  end

  // Clear address counter wraps to 0 on the final clear write
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
  end

  assign a_in  = ({1'b0, a_address} < DEPTH_W);
  assign b_in  = ({1'b0, b_address} < DEPTH_W);
  assign a_acc = a_en && !busy;
  assign b_acc = b_en && !busy;
  assign a_wr  = a_acc && a_write_en && a_in;
  assign a_old = mem[a_address];

  // Byte-lane merge of new write data over the stored word
  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_byte_en[i])
        a_merged[8*i +: 8] = a_data_in[8*i +: 8];
    end
  end

  // Read data selection; out-of-range reads return zero
  always_comb begin
    a_s1 = '0;
    b_s1 = '0;
    if (a_in) begin
      if (WRITE_MODE != 0 && a_write_en) a_s1 = a_merged;
      else                               a_s1 = a_old;
    end
    if (b_in) b_s1 = mem[b_address];
  end

  // Array write: clear engine owns the array while busy
  always_ff @(posedge clk) begin
    if (clr_we)    mem[clr_cnt]   <= '0;
    else if (a_wr) mem[a_address] <= a_merged;
  end

  // First read stage: data holds when idle, zero while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d1 <= '0;
      a_v1 <= 1'b0;
      b_d1 <= '0;
      b_v1 <= 1'b0;
    end else if (busy) begin
      a_d1 <= '0;
      a_v1 <= 1'b0;
      b_d1 <= '0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      if (a_acc) a_d1 <= a_s1;
      if (b_acc) b_d1 <= b_s1;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] a_d2;
      logic [DATA_WIDTH-1:0] b_d2;
      logic                  a_v2;
      logic                  b_v2;

      // Optional output stage, same hold/zero rules as stage one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_d2 <= '0;
          a_v2 <= 1'b0;
          b_d2 <= '0;
          b_v2 <= 1'b0;
        end else if (busy) begin
          a_d2 <= '0;
          a_v2 <= 1'b0;
          b_d2 <= '0;
          b_v2 <= 1'b0;
        end else begin
          a_v2 <= a_v1;
          b_v2 <= b_v1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end

      assign a_read_data = a_d2;
      assign a_valid     = a_v2;
      assign b_read_data = b_d2;
      assign b_valid     = b_v2;
    end else begin : g_lat1
      assign a_read_data = a_d1;
      assign a_valid     = a_v1;
      assign b_read_data = b_d1;
      assign b_valid     = b_v1;
    end
  endgenerate

endmodule

// File: tb/tb_memory_dp_clr.sv
// Bench for memory_dp_clr: two instances (latency 1 read-first and
// latency 2 write-first) share stimulus; a scoreboard checks every strobe.
module tb_memory_dp_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_en = 1'b0;
  logic        a_write_en = 1'b0;
  logic [1:0]  a_byte_en = 2'b00;
  logic [10:0] a_address = '0;
  logic [15:0] a_data_in = '0;
  logic        b_en = 1'b0;
  logic [10:0] b_address = '0;

  logic        busy1, busy2;
  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_v1, a_v2, b_v1, b_v2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t qa1[$];
  exp_t qa2[$];
  exp_t qb1[$];
  exp_t qb2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  memory_dp_clr u1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .a_en(a_en), .a_write_en(a_write_en),
    .a_byte_en(a_byte_en), .a_address(a_address),
    .a_data_in(a_data_in), .a_read_data(a_rd1),
    .a_valid(a_v1), .b_en(b_en), .b_address(b_address),
    .b_read_data(b_rd1), .b_valid(b_v1)
  );

  memory_dp_clr #(.READ_LATENCY(2), .WRITE_MODE(1)) u2 (
    .clk(clk), .rst(rst), .busy(busy2),
    .a_en(a_en), .a_write_en(a_write_en),
    .a_byte_en(a_byte_en), .a_address(a_address),
    .a_data_in(a_data_in), .a_read_data(a_rd2),
    .a_valid(a_v2), .b_en(b_en), .b_address(b_address),
    .b_read_data(b_rd2), .b_valid(b_v2)
  );

  // Scoreboard: each strobe pops one expectation and checks data and cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (a_v1 === 1'b1) begin
      total++;
      if (qa1.size() == 0) begin
        bad++;
        $display("FAIL a1_unexpected got=%h cyc=%0d", a_rd1, cyc);
      end else begin
        e = qa1.pop_front();
        if (a_rd1 !== e.d || cyc != e.due) begin
          bad++;
          $display("FAIL a1_read got=%h@%0d want=%h@%0d",
                   a_rd1, cyc, e.d, e.due);
        end
      end
    end else if (qa1.size() > 0 && qa1[0].due <= cyc) begin
      total++; bad++;
      e = qa1.pop_front();
      $display("FAIL a1_missing got=none want=%h@%0d", e.d, e.due);
    end
    if (a_v2 === 1'b1) begin
      total++;
      if (qa2.size() == 0) begin
        bad++;
        $display("FAIL a2_unexpected got=%h cyc=%0d", a_rd2, cyc);
      end else begin
        e = qa2.pop_front();
        if (a_rd2 !== e.d || cyc != e.due) begin
          bad++;
          $display("FAIL a2_read got=%h@%0d want=%h@%0d",
                   a_rd2, cyc, e.d, e.due);
        end
      end
    end else if (qa2.size() > 0 && qa2[0].due <= cyc) begin
      total++; bad++;
      e = qa2.pop_front();
      $display("FAIL a2_missing got=none want=%h@%0d", e.d, e.due);
    end
    if (b_v1 === 1'b1) begin
      total++;
      if (qb1.size() == 0) begin
        bad++;
        $display("FAIL b1_unexpected got=%h cyc=%0d", b_rd1, cyc);
      end else begin
        e = qb1.pop_front();
        if (b_rd1 !== e.d || cyc != e.due) begin
          bad++;
          $display("FAIL b1_read got=%h@%0d want=%h@%0d",
                   b_rd1, cyc, e.d, e.due);
        end
      end
    end else if (qb1.size() > 0 && qb1[0].due <= cyc) begin
      total++; bad++;
      e = qb1.pop_front();
      $display("FAIL b1_missing got=none want=%h@%0d", e.d, e.due);
    end
    if (b_v2 === 1'b1) begin
      total++;
      if (qb2.size() == 0) begin
        bad++;
        $display("FAIL b2_unexpected got=%h cyc=%0d", b_rd2, cyc);
      end else begin
        e = qb2.pop_front();
        if (b_rd2 !== e.d || cyc != e.due) begin
          bad++;
          $display("FAIL b2_read got=%h@%0d want=%h@%0d",
                   b_rd2, cyc, e.d, e.due);
        end
      end
    end else if (qb2.size() > 0 && qb2[0].due <= cyc) begin
      total++; bad++;
      e = qb2.pop_front();
      $display("FAIL b2_missing got=none want=%h@%0d", e.d, e.due);
    end
  end

  // One request cycle; ax1/ax2 are the port A results for u1/u2
  task automatic issue(
    input logic        ae,
    input logic        aw,
    input logic [1:0]  be,
    input logic [10:0] aa,
    input logic [15:0] ad,
    input logic [15:0] ax1,
    input logic [15:0] ax2,
    input logic        bn,
    input logic [10:0] ba,
    input logic [15:0] bx
  );
    exp_t e;
    @(negedge clk);
    a_en = ae; a_write_en = aw; a_byte_en = be;
    a_address = aa; a_data_in = ad;
    b_en = bn; b_address = ba;
    if (ae) begin
      e.d = ax1; e.due = cyc + 1; qa1.push_back(e);
      e.d = ax2; e.due = cyc + 2; qa2.push_back(e);
    end
    if (bn) begin
      e.d = bx; e.due = cyc + 1; qb1.push_back(e);
      e.due = cyc + 2; qb2.push_back(e);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    a_en = 1'b0; a_write_en = 1'b0; b_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy1 === 1'b1 && n < 5000);
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy got=%b%b want=11", busy1, busy2);
    end
    total++;
    if ({a_v1, b_v1, a_v2, b_v2} !== 4'b0 ||
        {a_rd1, b_rd1, a_rd2, b_rd2} !== 64'h0) begin
      bad++;
      $display("FAIL reset_out got=%b %h want=0 0",
               {a_v1, b_v1, a_v2, b_v2},
               {a_rd1, b_rd1, a_rd2, b_rd2});
    end
    rst = 1'b0;
    count_busy(n);
    total++;
    if (n != 2048) begin
      bad++;
      $display("FAIL clear_len got=%0d want=2048", n);
    end
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL clear_done2 got=%b want=0", busy2);
    end
    issue(1, 0, 2'b00, 11'h123, 16'h0, 16'h0, 16'h0,
          1, 11'h7FF, 16'h0);
    drain();
  endtask

  task automatic test_sweep();
    logic [10:0] ai;
    for (int i = 0; i < 2048; i++) begin
      ai = 11'(i);
      issue(1, 1, 2'b11, ai, 16'(i), 16'h0, 16'(i),
            0, 11'h0, 16'h0);
    end
    for (int i = 0; i < 2048; i++) begin
      ai = 11'(i);
      issue(1, 0, 2'b00, ai, 16'h0, 16'(i), 16'(i),
            1, ai ^ 11'd1, 16'(ai ^ 11'd1));
    end
    drain();
  endtask

  task automatic test_byte_lanes();
    issue(1, 1, 2'b11, 11'd5, 16'hABCD, 16'h0005, 16'hABCD,
          0, 11'd0, 16'h0);
    issue(1, 1, 2'b10, 11'd5, 16'h1234, 16'hABCD, 16'h12CD,
          0, 11'd0, 16'h0);
    issue(1, 1, 2'b00, 11'd5, 16'hFFFF, 16'h12CD, 16'h12CD,
          0, 11'd0, 16'h0);
    issue(1, 0, 2'b00, 11'd5, 16'h0, 16'h12CD, 16'h12CD,
          1, 11'd5, 16'h12CD);
    drain();
  endtask

  task automatic test_collision();
    issue(1, 1, 2'b11, 11'd7, 16'h1111, 16'h0007, 16'h1111,
          0, 11'd0, 16'h0);
    issue(1, 1, 2'b11, 11'd7, 16'h2222, 16'h1111, 16'h2222,
          1, 11'd7, 16'h1111);
    issue(0, 0, 2'b00, 11'd0, 16'h0, 16'h0, 16'h0,
          1, 11'd7, 16'h2222);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1, 0, 2'b00, 11'd10, 16'h0, 16'd10, 16'd10,
          1, 11'd1, 16'h0001);
    issue(1, 0, 2'b00, 11'd11, 16'h0, 16'd11, 16'd11,
          1, 11'd2, 16'h0002);
    issue(1, 0, 2'b00, 11'd12, 16'h0, 16'd12, 16'd12,
          1, 11'd3, 16'h0003);
    drain();
  endtask

  task automatic test_busy_gate();
    int n;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 ||
        {a_rd1, b_rd1, a_rd2, b_rd2} !== 64'h0) begin
      bad++;
      $display("FAIL rerst_out got=%b%b %h want=11 0",
               busy1, busy2, {a_rd1, b_rd1, a_rd2, b_rd2});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    a_en = 1'b1; a_write_en = 1'b1; a_byte_en = 2'b11;
    a_address = 11'd2000; a_data_in = 16'hFFFF;
    b_en = 1'b1; b_address = 11'd2000;
    @(negedge clk);
    a_en = 1'b0; a_write_en = 1'b0; b_en = 1'b0;
    total++;
    if ({a_v1, b_v1} !== 2'b00 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL busy_gate got=v%b busy%b want=v00 busy1",
               {a_v1, b_v1}, busy1);
    end
    repeat (399) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      bad++;
      $display("FAIL midclr_busy got=%b%b want=11", busy1, busy2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    total++;
    if (n != 2048) begin
      bad++;
      $display("FAIL reclear_len got=%0d want=2048", n);
    end
    issue(1, 0, 2'b00, 11'd2000, 16'h0, 16'h0, 16'h0,
          1, 11'd5, 16'h0);
    issue(1, 0, 2'b00, 11'd7, 16'h0, 16'h0, 16'h0,
          1, 11'd2000, 16'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_byte_lanes();
    test_collision();
    test_back_to_back();
    test_busy_gate();
    total++;
    if (qa1.size() + qa2.size() + qb1.size() + qb2.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0",
               qa1.size() + qa2.size() + qb1.size() + qb2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
